// File: rtl/wakeup_issue_queue_pkg.sv
// Shared scheduler definitions: source-operand record, tag width defaults, sizing helper.
package wakeup_issue_queue_pkg;

    // Default physical register tag width for schedulers in this pipe.
    localparam int unsigned IqPregWidthDflt = 6;

    // Stored tags are zero-extended to this width so one record type serves every
    // scheduler, whatever its PREG_WIDTH.
    localparam int unsigned IqTagWidthMax = 16;

    typedef logic [IqTagWidthMax-1:0] iq_tag_t;

    // One source operand: physical register tag and its ready bit.
    typedef struct packed {
        iq_tag_t tag;
        logic    rdy;
    } iq_src_t;

    // Index width for an n-entry structure, never narrower than one bit.
    function automatic int unsigned iq_idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wakeup_issue_queue_age_select.sv
// Age-matrix oldest-first selector: grant k is one-hot on the (k+1)-th oldest requester.
// older[i][j] = 1 means entry i is older than entry j. Bits involving
// non-requesting entries are ignored, so stale matrix bits are harmless.
module wakeup_issue_queue_age_select #(
    parameter int unsigned NUM_ENTRIES = 8,
    parameter int unsigned NUM_GRANTS  = 2
) (
    input  logic [NUM_ENTRIES-1:0] older [NUM_ENTRIES],
    input  logic [NUM_ENTRIES-1:0] req,
    output logic [NUM_ENTRIES-1:0] grant [NUM_GRANTS],
    output logic [NUM_GRANTS-1:0]  grant_valid
);

    localparam int unsigned CntW = $clog2(NUM_ENTRIES + 1);

    logic [CntW-1:0] rank [NUM_ENTRIES];

    // Rank of each entry = number of requesting entries older than it.
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            rank[i] = '0;
            for (int j = 0; j < NUM_ENTRIES; j++) begin
                if (req[j] && older[j][i]) begin
                    rank[i] = rank[i] + CntW'(1);
                end
            end
        end
    end

    // Grant k goes to the requester whose rank equals k; ranks are unique among requesters.
    always_comb begin
        for (int k = 0; k < NUM_GRANTS; k++) begin
            grant[k] = '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                grant[k][i] = req[i] && (rank[i] == CntW'(k));
            end
            grant_valid[k] = |grant[k];
        end
    end

endmodule

// File: rtl/wakeup_issue_queue.sv
// Out-of-order issue queue with tag-broadcast wakeup and age-ordered selection.
// ORDER_ISSUE=1 restricts issue to a contiguous ready prefix of the oldest entries.
module wakeup_issue_queue
    import wakeup_issue_queue_pkg::*;
#(
    parameter int unsigned QUEUE_SIZE  = 8,
    parameter int unsigned WPORTS_NUM  = 2,
    parameter int unsigned RPORTS_NUM  = 2,
    parameter int unsigned WAKEUP_NUM  = 4,
    parameter int unsigned SRC_NUM     = 2,
    parameter int unsigned PREG_WIDTH  = IqPregWidthDflt,
    parameter type         DATA_TYPE   = logic [31:0],
    parameter bit          ORDER_ISSUE = 1'b0
) (
    input  logic                            clk,
    input  logic                            a_rst_n,
    input  logic                            flush_i,
    input  logic [WPORTS_NUM-1:0]           write_valid_i,
    output logic [WPORTS_NUM-1:0]           write_ready_o,
    input  DATA_TYPE                        write_data_i [WPORTS_NUM],
    input  logic [PREG_WIDTH-1:0]           write_src_tag_i [WPORTS_NUM][SRC_NUM],
    input  logic [SRC_NUM-1:0]              write_src_rdy_i [WPORTS_NUM],
    input  logic [WAKEUP_NUM-1:0]           wakeup_valid_i,
    input  logic [PREG_WIDTH-1:0]           wakeup_tag_i [WAKEUP_NUM],
    output logic [RPORTS_NUM-1:0]           read_valid_o,
    input  logic [RPORTS_NUM-1:0]           read_ready_i,
    output DATA_TYPE                        read_data_o [RPORTS_NUM],
    output logic [$clog2(QUEUE_SIZE+1)-1:0] free_cnt_o
);

    localparam int unsigned IdxW = iq_idx_width(QUEUE_SIZE);
    localparam int unsigned CntW = $clog2(QUEUE_SIZE + 1);

    // Entry state
    logic [QUEUE_SIZE-1:0] valid_q, valid_d;
    DATA_TYPE              data_q  [QUEUE_SIZE];
    DATA_TYPE              data_d  [QUEUE_SIZE];
    iq_src_t               src_q   [QUEUE_SIZE][SRC_NUM];
    iq_src_t               src_d   [QUEUE_SIZE][SRC_NUM];
    logic [QUEUE_SIZE-1:0] older_q [QUEUE_SIZE];
    logic [QUEUE_SIZE-1:0] older_d [QUEUE_SIZE];
    logic [CntW-1:0]       free_cnt_q, free_cnt_d;

    // Wakeup / select / allocate intermediates
    logic [SRC_NUM-1:0]    ent_wake  [QUEUE_SIZE];
    logic [SRC_NUM-1:0]    wr_wake   [WPORTS_NUM];
    logic [QUEUE_SIZE-1:0] entry_rdy;
    logic [QUEUE_SIZE-1:0] sel_req;
    logic [QUEUE_SIZE-1:0] sel_grant [RPORTS_NUM];
    logic [RPORTS_NUM-1:0] sel_valid;
    logic [IdxW-1:0]       sel_idx   [RPORTS_NUM];
    logic [RPORTS_NUM-1:0] fire;
    logic [WPORTS_NUM-1:0] write_acc;
    logic [IdxW-1:0]       free_idx  [WPORTS_NUM];
    logic [IdxW-1:0]       port_slot [WPORTS_NUM];
    logic [CntW-1:0]       n_acc, n_fire;

    // Tag match of every stored source and every incoming source against the broadcasts.
    always_comb begin
        for (int i = 0; i < QUEUE_SIZE; i++) begin
            for (int s = 0; s < SRC_NUM; s++) begin
                ent_wake[i][s] = 1'b0;
                for (int w = 0; w < WAKEUP_NUM; w++) begin
                    if (wakeup_valid_i[w] && src_q[i][s].tag == iq_tag_t'(wakeup_tag_i[w])) begin
                        ent_wake[i][s] = valid_q[i];
                    end
                end
            end
        end
        for (int p = 0; p < WPORTS_NUM; p++) begin
            for (int s = 0; s < SRC_NUM; s++) begin
                wr_wake[p][s] = 1'b0;
                for (int w = 0; w < WAKEUP_NUM; w++) begin
                    if (wakeup_valid_i[w] && write_src_tag_i[p][s] == wakeup_tag_i[w]) begin
                        wr_wake[p][s] = 1'b1;
                    end
                end
            end
        end
    end

    // An entry is ready once it is valid and every source has been produced.
    always_comb begin
        for (int i = 0; i < QUEUE_SIZE; i++) begin
            entry_rdy[i] = valid_q[i];
            for (int s = 0; s < SRC_NUM; s++) begin
                entry_rdy[i] = entry_rdy[i] & src_q[i][s].rdy;
            end
        end
    end

    // In-order mode ranks all valid entries so a non-ready head blocks everything behind it.
    assign sel_req = ORDER_ISSUE ? valid_q : entry_rdy;

    wakeup_issue_queue_age_select #(
        .NUM_ENTRIES (QUEUE_SIZE),
        .NUM_GRANTS  (RPORTS_NUM)
    ) u_age_select (
        .older       (older_q),
        .req         (sel_req),
        .grant       (sel_grant),
        .grant_valid (sel_valid)
    );

    // Issue ports: one-hot grant to index, valid/fire qualification, payload mux.
    always_comb begin
        logic vld_pre;
        logic fire_pre;
        vld_pre  = 1'b1;
        fire_pre = 1'b1;
        for (int k = 0; k < RPORTS_NUM; k++) begin
            sel_idx[k] = '0;
            for (int i = 0; i < QUEUE_SIZE; i++) begin
                if (sel_grant[k][i]) begin
                    sel_idx[k] = IdxW'(i);
                end
            end
            if (ORDER_ISSUE) begin
                read_valid_o[k] = vld_pre && sel_valid[k] && entry_rdy[sel_idx[k]];
                fire[k]         = fire_pre && read_valid_o[k] && read_ready_i[k];
                vld_pre         = read_valid_o[k];
                fire_pre        = fire[k];
            end else begin
                read_valid_o[k] = sel_valid[k];
                fire[k]         = read_valid_o[k] && read_ready_i[k];
            end
            read_data_o[k] = data_q[sel_idx[k]];
        end
    end

    // Write acceptance depends only on the registered free count.
    always_comb begin
        for (int p = 0; p < WPORTS_NUM; p++) begin
            write_ready_o[p] = free_cnt_q > CntW'(p);
        end
        write_acc = write_valid_i & write_ready_o;
    end

    // Priority encoder: the WPORTS_NUM lowest-index free slots, lowest first.
    always_comb begin
        int cnt;
        cnt = 0;
        for (int n = 0; n < WPORTS_NUM; n++) begin
            free_idx[n] = '0;
        end
        for (int i = 0; i < QUEUE_SIZE; i++) begin
            if (!valid_q[i]) begin
                for (int n = 0; n < WPORTS_NUM; n++) begin
                    if (cnt == n) begin
                        free_idx[n] = IdxW'(i);
                    end
                end
                cnt++;
            end
        end
    end

    // Accepted ports take free slots in port order, skipping sparse (idle) ports.
    always_comb begin
        int rank;
        rank  = 0;
        n_acc = '0;
        for (int p = 0; p < WPORTS_NUM; p++) begin
            port_slot[p] = '0;
            if (write_acc[p]) begin
                port_slot[p] = free_idx[rank];
                rank++;
                n_acc = n_acc + CntW'(1);
            end
        end
        n_fire = '0;
        for (int k = 0; k < RPORTS_NUM; k++) begin
            if (fire[k]) begin
                n_fire = n_fire + CntW'(1);
            end
        end
    end

    // Next state: wakeup, retire fired entries, allocate writes, update ages, flush.
    always_comb begin
        logic [QUEUE_SIZE-1:0] new_mask;
        new_mask = '0;
        valid_d  = valid_q;
        data_d   = data_q;
        older_d  = older_q;
        for (int i = 0; i < QUEUE_SIZE; i++) begin
            for (int s = 0; s < SRC_NUM; s++) begin
                src_d[i][s]     = src_q[i][s];
                src_d[i][s].rdy = src_q[i][s].rdy | ent_wake[i][s];
            end
        end
        for (int k = 0; k < RPORTS_NUM; k++) begin
            if (fire[k]) begin
                valid_d[sel_idx[k]] = 1'b0;
            end
        end
        for (int p = 0; p < WPORTS_NUM; p++) begin
            if (write_acc[p]) begin
                valid_d[port_slot[p]] = 1'b1;
                data_d[port_slot[p]]  = write_data_i[p];
                for (int s = 0; s < SRC_NUM; s++) begin
                    src_d[port_slot[p]][s].tag = iq_tag_t'(write_src_tag_i[p][s]);
                    src_d[port_slot[p]][s].rdy = write_src_rdy_i[p][s] | wr_wake[p][s];
                end
                // Younger than every existing entry and every lower-port write this cycle.
                for (int j = 0; j < QUEUE_SIZE; j++) begin
                    older_d[j][port_slot[p]] = valid_q[j] | new_mask[j];
                end
                older_d[port_slot[p]]  = '0;
                new_mask[port_slot[p]] = 1'b1;
            end
        end
        free_cnt_d = free_cnt_q - n_acc + n_fire;
        if (flush_i) begin
            valid_d    = '0;
            free_cnt_d = CntW'(QUEUE_SIZE);
        end
    end

    // State registers; reset drops every entry immediately.
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            valid_q    <= '0;
            free_cnt_q <= CntW'(QUEUE_SIZE);
            for (int i = 0; i < QUEUE_SIZE; i++) begin
                data_q[i]  <= '0;
                older_q[i] <= '0;
                for (int s = 0; s < SRC_NUM; s++) begin
                    src_q[i][s] <= '0;
                end
            end
        end else begin
            valid_q    <= valid_d;
            free_cnt_q <= free_cnt_d;
            data_q     <= data_d;
            older_q    <= older_d;
            src_q      <= src_d;
        end
    end

    assign free_cnt_o = free_cnt_q;

endmodule

// File: tb/tb_wakeup_issue_queue.sv
// Directed bench: one out-of-order and one in-order queue driven by the same stimulus.
module tb_wakeup_issue_queue;

    logic        clk = 1'b0;
    logic        a_rst_n;
    logic        flush;
    logic [1:0]  write_valid;
    logic [31:0] write_data [2];
    logic [5:0]  write_src_tag [2][2];
    logic [1:0]  write_src_rdy [2];
    logic [3:0]  wakeup_valid;
    logic [5:0]  wakeup_tag [4];
    logic [1:0]  read_ready;

    logic [1:0]  ooo_write_ready, ino_write_ready;
    logic [1:0]  ooo_read_valid, ino_read_valid;
    logic [31:0] ooo_read_data [2];
    logic [31:0] ino_read_data [2];
    logic [3:0]  ooo_free_cnt, ino_free_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wakeup_issue_queue #(
        .ORDER_ISSUE (1'b0)
    ) dut_ooo (
        .clk             (clk),
        .a_rst_n         (a_rst_n),
        .flush_i         (flush),
        .write_valid_i   (write_valid),
        .write_ready_o   (ooo_write_ready),
        .write_data_i    (write_data),
        .write_src_tag_i (write_src_tag),
        .write_src_rdy_i (write_src_rdy),
        .wakeup_valid_i  (wakeup_valid),
        .wakeup_tag_i    (wakeup_tag),
        .read_valid_o    (ooo_read_valid),
        .read_ready_i    (read_ready),
        .read_data_o     (ooo_read_data),
        .free_cnt_o      (ooo_free_cnt)
    );

    wakeup_issue_queue #(
        .ORDER_ISSUE (1'b1)
    ) dut_ino (
        .clk             (clk),
        .a_rst_n         (a_rst_n),
        .flush_i         (flush),
        .write_valid_i   (write_valid),
        .write_ready_o   (ino_write_ready),
        .write_data_i    (write_data),
        .write_src_tag_i (write_src_tag),
        .write_src_rdy_i (write_src_rdy),
        .wakeup_valid_i  (wakeup_valid),
        .wakeup_tag_i    (wakeup_tag),
        .read_valid_o    (ino_read_valid),
        .read_ready_i    (read_ready),
        .read_data_o     (ino_read_data),
        .free_cnt_o      (ino_free_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        flush        = 1'b0;
        write_valid  = '0;
        wakeup_valid = '0;
        read_ready   = '0;
        for (int p = 0; p < 2; p++) begin
            write_data[p]       = '0;
            write_src_tag[p][0] = '0;
            write_src_tag[p][1] = '0;
            write_src_rdy[p]    = '0;
        end
        for (int w = 0; w < 4; w++) begin
            wakeup_tag[w] = '0;
        end
    endtask

    // Source 1 is always ready; source 0 carries the tag under test.
    task automatic put(input int p, input logic [31:0] d, input logic [5:0] tag, input logic rdy);
        write_valid[p]      = 1'b1;
        write_data[p]       = d;
        write_src_tag[p][0] = tag;
        write_src_rdy[p][0] = rdy;
        write_src_tag[p][1] = 6'd0;
        write_src_rdy[p][1] = 1'b1;
    endtask

    task automatic wake(input int w, input logic [5:0] tag);
        wakeup_valid[w] = 1'b1;
        wakeup_tag[w]   = tag;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        a_rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("rst_free", 32'(ooo_free_cnt), 32'd8);
        check("rst_wready", 32'(ooo_write_ready), 32'b11);
        check("rst_rvalid", 32'(ooo_read_valid), 32'b00);
        check("rst_ino_rvalid", 32'(ino_read_valid), 32'b00);
        #2 a_rst_n = 1'b1;
        step();

        // Two ready writes, issued the next cycle, then both fire.
        put(0, 32'hA0, 6'd0, 1'b1);
        put(1, 32'hA1, 6'd0, 1'b1);
        step();
        check("t1_rvalid", 32'(ooo_read_valid), 32'b11);
        check("t1_data0", ooo_read_data[0], 32'hA0);
        check("t1_data1", ooo_read_data[1], 32'hA1);
        check("t1_free", 32'(ooo_free_cnt), 32'd6);
        check("t1_ino_rvalid", 32'(ino_read_valid), 32'b11);
        read_ready = 2'b11;
        step();
        check("t1_free_after", 32'(ooo_free_cnt), 32'd8);
        check("t1_rvalid_after", 32'(ooo_read_valid), 32'b00);
        check("t1_ino_free_after", 32'(ino_free_cnt), 32'd8);

        // Fill with eight entries waiting on tag 5.
        for (int c = 0; c < 4; c++) begin
            put(0, 32'hB0 + 32'(2 * c), 6'd5, 1'b0);
            put(1, 32'hB1 + 32'(2 * c), 6'd5, 1'b0);
            step();
            check("t2_fill_free", 32'(ooo_free_cnt), 32'(6 - 2 * c));
        end
        check("t2_full_wready", 32'(ooo_write_ready), 32'b00);
        check("t2_full_rvalid", 32'(ooo_read_valid), 32'b00);
        wake(0, 6'd6);
        step();
        check("t2_wrong_tag", 32'(ooo_read_valid), 32'b00);
        wake(2, 6'd5);
        step();
        check("t2_wake_rvalid", 32'(ooo_read_valid), 32'b11);
        check("t2_wake_data0", ooo_read_data[0], 32'hB0);
        check("t2_wake_data1", ooo_read_data[1], 32'hB1);
        check("t2_ino_rvalid", 32'(ino_read_valid), 32'b11);
        read_ready = 2'b11;
        put(0, 32'hEE, 6'd0, 1'b1);  // dropped: queue full
        step();
        check("t2_fire_free", 32'(ooo_free_cnt), 32'd2);
        check("t2_next_data0", ooo_read_data[0], 32'hB2);
        check("t2_next_data1", ooo_read_data[1], 32'hB3);
        check("t2_wready_after", 32'(ooo_write_ready), 32'b11);
        repeat (3) begin
            read_ready = 2'b11;
            step();
        end
        check("t2_drain_free", 32'(ooo_free_cnt), 32'd8);
        check("t2_ino_drain_free", 32'(ino_free_cnt), 32'd8);

        // Same-cycle wakeup bypass on a dispatched source.
        put(0, 32'hC0, 6'd9, 1'b0);
        wake(1, 6'd9);
        step();
        check("t3_rvalid", 32'(ooo_read_valid), 32'b01);
        check("t3_data0", ooo_read_data[0], 32'hC0);
        check("t3_ino_rvalid", 32'(ino_read_valid), 32'b01);
        read_ready = 2'b01;
        step();
        check("t3_free", 32'(ooo_free_cnt), 32'd8);

        // Oldest blocked, younger ready.
        put(0, 32'hD0, 6'd3, 1'b0);
        put(1, 32'hD1, 6'd0, 1'b1);
        step();
        check("t4_rvalid", 32'(ooo_read_valid), 32'b01);
        check("t4_data0", ooo_read_data[0], 32'hD1);
        check("t4_ino_rvalid", 32'(ino_read_valid), 32'b00);
        put(0, 32'hD2, 6'd0, 1'b1);
        step();
        check("t4_rvalid2", 32'(ooo_read_valid), 32'b11);
        check("t4_data0_2", ooo_read_data[0], 32'hD1);
        check("t4_data1_2", ooo_read_data[1], 32'hD2);
        check("t4_free2", 32'(ooo_free_cnt), 32'd5);
        read_ready = 2'b10;
        step();
        check("t4_p1only_rvalid", 32'(ooo_read_valid), 32'b01);
        check("t4_p1only_data0", ooo_read_data[0], 32'hD1);
        check("t4_p1only_free", 32'(ooo_free_cnt), 32'd6);
        check("t4_ino_free", 32'(ino_free_cnt), 32'd5);
        check("t4_ino_blocked", 32'(ino_read_valid), 32'b00);
        wake(3, 6'd3);
        step();
        check("t4_wake_rvalid", 32'(ooo_read_valid), 32'b11);
        check("t4_wake_data0", ooo_read_data[0], 32'hD0);
        check("t4_wake_data1", ooo_read_data[1], 32'hD1);
        check("t4_ino_wake_rvalid", 32'(ino_read_valid), 32'b11);
        check("t4_ino_wake_data0", ino_read_data[0], 32'hD0);
        check("t4_ino_wake_data1", ino_read_data[1], 32'hD1);
        read_ready = 2'b10;
        step();
        check("t4_ino_noprefix_free", 32'(ino_free_cnt), 32'd5);
        check("t4_ino_noprefix_rvalid", 32'(ino_read_valid), 32'b11);
        check("t4_ino_noprefix_data0", ino_read_data[0], 32'hD0);
        check("t4_ooo_p1_free", 32'(ooo_free_cnt), 32'd7);
        check("t4_ooo_p1_rvalid", 32'(ooo_read_valid), 32'b01);
        check("t4_ooo_p1_data0", ooo_read_data[0], 32'hD0);
        read_ready = 2'b01;
        step();
        check("t4_ino_head_free", 32'(ino_free_cnt), 32'd6);
        check("t4_ino_head_data0", ino_read_data[0], 32'hD1);
        check("t4_ino_head_data1", ino_read_data[1], 32'hD2);

        // Flush with five entries and two same-cycle writes.
        flush = 1'b1;
        step();
        check("t5_flush0_free", 32'(ino_free_cnt), 32'd8);
        put(0, 32'hE0, 6'd0, 1'b1);
        put(1, 32'hE1, 6'd0, 1'b1);
        step();
        put(0, 32'hE2, 6'd0, 1'b1);
        put(1, 32'hE3, 6'd0, 1'b1);
        step();
        put(1, 32'hE4, 6'd0, 1'b1);  // sparse: port 1 only
        step();
        check("t5_five_free", 32'(ooo_free_cnt), 32'd3);
        check("t5_five_data0", ooo_read_data[0], 32'hE0);
        flush = 1'b1;
        put(0, 32'hF0, 6'd0, 1'b1);
        put(1, 32'hF1, 6'd0, 1'b1);
        step();
        check("t5_flush_free", 32'(ooo_free_cnt), 32'd8);
        check("t5_flush_rvalid", 32'(ooo_read_valid), 32'b00);
        check("t5_ino_flush_free", 32'(ino_free_cnt), 32'd8);
        check("t5_ino_flush_rvalid", 32'(ino_read_valid), 32'b00);

        // Asynchronous reset between edges drops the entry at once.
        put(0, 32'hA5, 6'd0, 1'b1);
        step();
        check("t6_pre_free", 32'(ooo_free_cnt), 32'd7);
        #2 a_rst_n = 1'b0;
        #1;
        check("t6_async_free", 32'(ooo_free_cnt), 32'd8);
        check("t6_async_rvalid", 32'(ooo_read_valid), 32'b00);
        #1 a_rst_n = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wakeup_issue_queue.md
# wakeup_issue_queue

Parametrised out-of-order issue queue for the scheduler stage. Each entry holds an opaque micro-op payload plus up to SRC_NUM physical-register source tags with ready bits. Entries are woken by writeback tag broadcasts, and the oldest ready entries are selected onto up to RPORTS_NUM read ports. An optional in-order mode restricts issue to a contiguous oldest prefix, for memory and CSR pipes.

## Interface
- QUEUE_SIZE, 8, number of entries (≥ WPORTS_NUM, ≥ RPORTS_NUM)
- WPORTS_NUM, 2, dispatch (write) ports per cycle
- RPORTS_NUM, 2, issue (read) ports per cycle
- WAKEUP_NUM, 4, writeback tag broadcast ports
- SRC_NUM, 2, source operands per entry
- PREG_WIDTH, 6, physical register tag width
- DATA_TYPE, logic [31:0], payload type, opaque to this block
- ORDER_ISSUE, 0, 1 = in-order issue mode

Ports:
- clk  in  1  clock, all state on rising edge
- a_rst_n  in  1  asynchronous reset, active low
- flush_i  in  1  synchronous flush, clears all entries
- write_valid_i  in  WPORTS_NUM  dispatch request per port
- write_ready_o  out  WPORTS_NUM  port may be accepted this cycle
- write_data_i  in  WPORTS_NUM×DATA_TYPE  payload
- write_src_tag_i  in  WPORTS_NUM×SRC_NUM×PREG_WIDTH  source tags
- write_src_rdy_i  in  WPORTS_NUM×SRC_NUM  source already ready at dispatch
- wakeup_valid_i  in  WAKEUP_NUM  broadcast valid
- wakeup_tag_i  in  WAKEUP_NUM×PREG_WIDTH  broadcast tag
- read_valid_o  out  RPORTS_NUM  issue candidate present
- read_ready_i  in  RPORTS_NUM  consumer accepts
- read_data_o  out  RPORTS_NUM×DATA_TYPE  selected payload
- free_cnt_o  out  $clog2(QUEUE_SIZE+1)  registered free-entry count

## Operation
- Entry state: valid, payload, src_tag[SRC_NUM], src_rdy[SRC_NUM]. Ages are kept in a QUEUE_SIZE² age matrix: older[i][j]=1 means entry i is older than entry j.
- Write acceptance: write_ready_o[i] = (free_cnt > i). It depends only on registered state, with no combinational path from read_ready_i or write_valid_i. Port i is accepted iff write_valid_i[i] && write_ready_o[i]. Sparse valids are allowed.
- Allocation: accepted ports take the lowest-index free entries in port order. A new entry is younger than every existing entry. Among same-cycle writes, the lower port is older.
- Wakeup: for each valid entry source, src_rdy is set when any wakeup_valid_i[w] && wakeup_tag_i[w]==src_tag. Same-cycle bypass applies: an incoming write source matching a same-cycle wakeup is stored ready.
- Entry ready = valid && all src_rdy.
- OoO select (ORDER_ISSUE=0): port 0 takes the oldest ready entry, port k the (k+1)-th oldest ready entry. read_valid_o[k] = such an entry exists. A port whose handshake does not fire leaves its entry in place. Other ports still fire independently.
- In-order select (ORDER_ISSUE=1): port k is valid iff the k oldest valid entries (0..k) are all ready and port k-1 is valid. Port k fires only if ports 0..k-1 also fire this cycle. A non-prefix read_ready_i pattern fires only the prefix.
- Fire (read_valid_o[k] && read_ready_i[k]) invalidates the entry at the next edge. The freed slot is reusable from the following cycle.
- flush_i: all entries are invalidated at the edge and free_cnt = QUEUE_SIZE. Same-cycle writes and wakeups are discarded.

## Timing
- Reset: all valid=0, read_valid_o=0, write_ready_o all 1, free_cnt_o=QUEUE_SIZE, age matrix 0. Reset mid-operation drops all entries immediately (asynchronous).
- Write at edge N: the entry is selectable in cycle N+1 if ready. Minimum dispatch-to-issue latency is 1 cycle.
- Wakeup in cycle N: the affected entry asserts read_valid_o in cycle N+1.
- read_valid_o and read_data_o are combinational from registered entry state only.
- free_cnt(N+1) = free_cnt(N) − accepted writes + fired reads. Reads in cycle N do not raise write_ready_o until N+1.
- Full (free_cnt=0): write_ready_o=0. Empty: read_valid_o=0.
- Simultaneous events: a read and a write to different slots in the same cycle are independent. A freed slot is never written in the same cycle.

## Structure
- Shared scheduler package holds `iq_src_t` (tag + rdy) and the `PREG_WIDTH` default.
- Sub-module `age_select`: takes the age matrix and request vector, and returns the RPORTS_NUM oldest one-hot grants. It is reused by other schedulers.
- Allocation uses a priority encoder over the free vector (QUEUE_SIZE entries, WPORTS_NUM picks).

## Test plan
- Reset then write 2 ready µops (ports 0,1) in cycle 0: cycle 1 read_valid_o=2'b11, port 0 carries the port-0 payload. Fire both: free_cnt_o returns to 8 in cycle 2.
- Fill 8 non-ready entries with src tag 5: write_ready_o=0, free_cnt_o=0. Wakeup tag 5 in cycle N: cycle N+1 shows the two oldest entries on ports 0/1.
- Write an entry with src tag 9 in the same cycle as wakeup tag 9: the entry issues next cycle.
- OoO: oldest entry not ready, younger entry ready: port 0 issues the younger one. Read_ready_i=2'b10 with two candidates: only port 1 fires, and the port-0 entry remains.
- ORDER_ISSUE=1: oldest entry not ready, second ready: read_valid_o=0. Read_ready_i=2'b10 with both valid: nothing fires.
- Flush with 5 entries plus 2 same-cycle writes: next cycle free_cnt_o=8, read_valid_o=0.
